// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the tx and rx blocks: FSM state
// encodings and bit-timing constants for the 16x oversampled baud tick.
package uart_pkg;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   localparam int TICKS_PER_BIT = 16;
   localparam int TICK_W        = 4;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bits.
// Define UART_TX_PARITY_EN to insert the even-parity bit between data and stop.
module uart_tx
   import uart_pkg::*;
#(
   parameter int WIDTH_WORD    = 8,
   parameter int CANT_BIT_STOP = 2
) (
   input  logic                  i_rate,
   input  logic                  i_reset,
   input  logic                  i_tx_start,
   input  logic [WIDTH_WORD-1:0] i_data_in,
   output logic                  o_bit_tx,
   output logic                  o_tx_busy,
   output logic                  o_tx_done
);

   localparam int BIT_CNT_W  = $clog2(WIDTH_WORD + 1);
   localparam int STOP_CNT_W = $clog2(CANT_BIT_STOP + 1);

   localparam logic [TICK_W-1:0]     LAST_TICK = TICK_W'(TICKS_PER_BIT - 1);
   localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(WIDTH_WORD - 1);
   localparam logic [STOP_CNT_W-1:0] LAST_STOP = STOP_CNT_W'(CANT_BIT_STOP - 1);

   logic [2:0]            state;
   logic [TICK_W-1:0]     tick_cnt;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   logic [STOP_CNT_W-1:0] stop_cnt;
   logic [WIDTH_WORD-1:0] shift_reg;
   logic [WIDTH_WORD-1:0] shift_next;
   logic                  tick_end;
`ifdef UART_TX_PARITY_EN
   logic                  parity_bit;
`endif

   assign shift_next = shift_reg >> 1;
   assign tick_end   = (tick_cnt == LAST_TICK);

   // o_bit_tx is loaded with the level of the state being entered, so the
   // line changes exactly on the edge that changes state.
   always_ff @(posedge i_rate) begin
      if (i_reset) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         stop_cnt  <= '0;
         shift_reg <= '0;
         o_bit_tx  <= 1'b1;
         o_tx_busy <= 1'b0;
         o_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         o_tx_done <= 1'b0;
         if (state == IDLE) begin
            tick_cnt <= '0;
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               o_bit_tx <= 1'b1;
               if (i_tx_start) begin
                  shift_reg <= i_data_in;
`ifdef UART_TX_PARITY_EN
                  parity_bit <= ^i_data_in;
`endif
                  state     <= START;
                  o_tx_busy <= 1'b1;
                  o_bit_tx  <= 1'b0;
               end
            end
            START: begin
               if (tick_end) begin
                  state    <= DATA;
                  bit_cnt  <= '0;
                  o_bit_tx <= shift_reg[0];
               end
            end
            DATA: begin
               if (tick_end) begin
                  shift_reg <= shift_next;
                  bit_cnt   <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                     state    <= PARITY;
                     o_bit_tx <= parity_bit;
`else
                     state    <= STOP;
                     stop_cnt <= '0;
                     o_bit_tx <= 1'b1;
`endif
                  end else begin
                     o_bit_tx <= shift_next[0];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (tick_end) begin
                  state    <= STOP;
                  stop_cnt <= '0;
                  o_bit_tx <= 1'b1;
               end
            end
`endif
            STOP: begin
               o_bit_tx <= 1'b1;
               if (tick_end) begin
                  if (stop_cnt == LAST_STOP) begin
                     state     <= IDLE;
                     o_tx_busy <= 1'b0;
                     o_tx_done <= 1'b1;
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               o_bit_tx  <= 1'b1;
               o_tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx (8 data bits, 2 stop bits);
// parity checks are compiled in when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FRAME_LEN = 16 * (1 + 8 + 2 + PAR);

   logic       i_rate;
   logic       i_reset;
   logic       i_tx_start;
   logic [7:0] i_data_in;
   logic       o_bit_tx;
   logic       o_tx_busy;
   logic       o_tx_done;

   int checks;
   int errors;
   int cyc;
   bit line_buf [0:511];

   uart_tx #(.WIDTH_WORD(8), .CANT_BIT_STOP(2)) dut (
      .i_rate     (i_rate),
      .i_reset    (i_reset),
      .i_tx_start (i_tx_start),
      .i_data_in  (i_data_in),
      .o_bit_tx   (o_bit_tx),
      .o_tx_busy  (o_tx_busy),
      .o_tx_done  (o_tx_done)
   );

   initial i_rate = 1'b0;
   always #5 i_rate = ~i_rate;

   initial cyc = 0;
   always @(posedge i_rate) cyc <= cyc + 1;

   // Waits for the line to drop, records it cycle by cycle until the done
   // pulse, then decodes each bit from the middle of its 16-cycle window.
   task automatic capture_frame(output logic [7:0] word, output logic start_bit,
                                output logic par, output logic [1:0] stops,
                                output int len, output int glitches,
                                output int busy_low, output int t0,
                                output int tdone, output bit timeout);
      int n;
      word = '0; start_bit = 1'b1; par = 1'b0; stops = '0;
      len = 0; glitches = 0; busy_low = 0; t0 = 0; tdone = 0; timeout = 1'b0;
      n = 0;
      @(negedge i_rate);
      while (o_bit_tx !== 1'b0 && n < 1000) begin
         @(negedge i_rate);
         n++;
      end
      if (n >= 1000) begin
         timeout = 1'b1;
         return;
      end
      t0 = cyc;
      for (int i = 0; i < 400; i++) begin
         if (i > 0) @(negedge i_rate);
         if (o_tx_done === 1'b1) begin
            len   = i;
            tdone = cyc;
            break;
         end
         line_buf[i] = o_bit_tx;
         if (o_tx_busy !== 1'b1) busy_low++;
      end
      if (len == 0) begin
         timeout = 1'b1;
         return;
      end
      start_bit = line_buf[8];
      for (int k = 0; k < 8; k++) word[k] = line_buf[16 * (k + 1) + 8];
      if (PAR == 1) par = line_buf[16 * 9 + 8];
      stops[0] = line_buf[16 * (9 + PAR) + 8];
      stops[1] = line_buf[16 * (10 + PAR) + 8];
      for (int i = 0; i < len; i++)
         if (line_buf[i] != line_buf[16 * (i / 16) + 8]) glitches++;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      i_tx_start = 1'b1;
      i_data_in = 8'h00;
      for (int i = 0; i < 4; i++) begin
         @(negedge i_rate);
         checks++;
         if ({o_bit_tx, o_tx_busy, o_tx_done} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL reset_outputs cycle %0d: got line/busy/done=%b, want 100",
                     i, {o_bit_tx, o_tx_busy, o_tx_done});
         end
      end
      i_reset = 1'b0;
      i_tx_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge i_rate);
         checks++;
         if ({o_bit_tx, o_tx_busy, o_tx_done} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL reset_start_ignored cycle %0d: got %b, want 100",
                     i, {o_bit_tx, o_tx_busy, o_tx_done});
         end
      end
   endtask

   task automatic test_single_frame(input logic [7:0] data);
      logic [7:0] word;
      logic sb, par;
      logic [1:0] st;
      int len, gl, bl, t0, td;
      bit to;
      i_data_in = data;
      i_tx_start = 1'b1;
      fork
         capture_frame(word, sb, par, st, len, gl, bl, t0, td, to);
         begin
            @(negedge i_rate);
            i_tx_start = 1'b0;
         end
      join
      checks++;
      if (to) begin
         errors++;
         $display("[TB] FAIL single_timeout: no complete frame for %h", data);
         return;
      end
      checks++;
      if (sb !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_start_bit: got %b, want 0", sb);
      end
      checks++;
      if (word !== data) begin
         errors++;
         $display("[TB] FAIL single_data: got %h, want %h", word, data);
      end
      checks++;
      if (st !== 2'b11) begin
         errors++;
         $display("[TB] FAIL single_stop_bits: got %b, want 11", st);
      end
      checks++;
      if (len !== FRAME_LEN) begin
         errors++;
         $display("[TB] FAIL single_frame_len: got %0d, want %0d", len, FRAME_LEN);
      end
      checks++;
      if (gl !== 0 || bl !== 0) begin
         errors++;
         $display("[TB] FAIL single_bit_hold: glitches %0d busy_low %0d, want 0 0", gl, bl);
      end
      @(negedge i_rate);
      checks++;
      if ({o_bit_tx, o_tx_busy, o_tx_done} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL single_after_done: got %b, want 100",
                  {o_bit_tx, o_tx_busy, o_tx_done});
      end
   endtask

   task automatic test_busy_ignore();
      logic [7:0] word;
      logic sb, par;
      logic [1:0] st;
      int len, gl, bl, t0, td, extra_done, line_low;
      bit to;
      i_data_in = 8'h96;
      i_tx_start = 1'b1;
      fork
         capture_frame(word, sb, par, st, len, gl, bl, t0, td, to);
         begin
            @(negedge i_rate);
            i_tx_start = 1'b0;
            repeat (50) @(negedge i_rate);
            i_data_in = 8'hFF;
            i_tx_start = 1'b1;
            @(negedge i_rate);
            i_tx_start = 1'b0;
         end
      join
      checks++;
      if (to || word !== 8'h96 || len !== FRAME_LEN) begin
         errors++;
         $display("[TB] FAIL busy_ignore_frame: timeout %0d data %h len %0d, want 96 len %0d",
                  to, word, len, FRAME_LEN);
      end
      extra_done = 0;
      line_low = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge i_rate);
         if (o_tx_done === 1'b1) extra_done++;
         if (o_bit_tx !== 1'b1) line_low++;
      end
      checks++;
      if (extra_done !== 0 || line_low !== 0) begin
         errors++;
         $display("[TB] FAIL busy_ignore_extra: extra done %0d low cycles %0d, want 0 0",
                  extra_done, line_low);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w1, w2;
      logic sb1, sb2, p1, p2;
      logic [1:0] st1, st2;
      int len1, len2, gl1, gl2, bl1, bl2, t01, t02, td1, td2;
      bit to1, to2;
      i_data_in = 8'h55;
      i_tx_start = 1'b1;
      capture_frame(w1, sb1, p1, st1, len1, gl1, bl1, t01, td1, to1);
      i_data_in = 8'hA3;
      fork
         capture_frame(w2, sb2, p2, st2, len2, gl2, bl2, t02, td2, to2);
         begin
            @(negedge i_rate);
            i_tx_start = 1'b0;
         end
      join
      checks++;
      if (to1 || w1 !== 8'h55 || st1 !== 2'b11 || len1 !== FRAME_LEN) begin
         errors++;
         $display("[TB] FAIL b2b_frame1: timeout %0d data %h stops %b len %0d, want 55 11 %0d",
                  to1, w1, st1, len1, FRAME_LEN);
      end
      checks++;
      if (to2 || w2 !== 8'hA3 || st2 !== 2'b11 || len2 !== FRAME_LEN) begin
         errors++;
         $display("[TB] FAIL b2b_frame2: timeout %0d data %h stops %b len %0d, want a3 11 %0d",
                  to2, w2, st2, len2, FRAME_LEN);
      end
      checks++;
      if (t02 - td1 !== 1) begin
         errors++;
         $display("[TB] FAIL b2b_gap: got %0d idle cycles, want 1", t02 - td1);
      end
      checks++;
      if (td2 - td1 !== FRAME_LEN + 1) begin
         errors++;
         $display("[TB] FAIL b2b_done_spacing: got %0d, want %0d", td2 - td1, FRAME_LEN + 1);
      end
      repeat (5) @(negedge i_rate);
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      i_data_in = 8'hC7;
      i_tx_start = 1'b1;
      @(negedge i_rate);
      i_tx_start = 1'b0;
      checks++;
      if (o_bit_tx !== 1'b0 || o_tx_busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_frame_started: got line %b busy %b, want 0 1",
                  o_bit_tx, o_tx_busy);
      end
      repeat (59) @(negedge i_rate);
      i_reset = 1'b1;
      @(negedge i_rate);
      checks++;
      if ({o_bit_tx, o_tx_busy, o_tx_done} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL midreset_abort: got line/busy/done=%b, want 100",
                  {o_bit_tx, o_tx_busy, o_tx_done});
      end
      @(negedge i_rate);
      i_reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge i_rate);
         if ({o_bit_tx, o_tx_busy, o_tx_done} !== 3'b100) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("[TB] FAIL midreset_quiet: got %0d active cycles, want 0", bad);
      end
      test_single_frame(8'h3C);
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity(input logic [7:0] data, input logic want_par);
      logic [7:0] word;
      logic sb, par;
      logic [1:0] st;
      int len, gl, bl, t0, td;
      bit to;
      i_data_in = data;
      i_tx_start = 1'b1;
      fork
         capture_frame(word, sb, par, st, len, gl, bl, t0, td, to);
         begin
            @(negedge i_rate);
            i_tx_start = 1'b0;
         end
      join
      checks++;
      if (to || par !== want_par || word !== data || len !== 192) begin
         errors++;
         $display("[TB] FAIL parity_%h: timeout %0d parity %b data %h len %0d, want %b %h 192",
                  data, to, par, word, len, want_par, data);
      end
      repeat (3) @(negedge i_rate);
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      i_reset = 1'b1;
      i_tx_start = 1'b0;
      i_data_in = 8'h00;
      test_reset();
      test_single_frame(8'h96);
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
      test_parity(8'h96, 1'b0);
      test_parity(8'h97, 1'b1);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
